// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit out-of-order core: architectural sizes
// and the reorder-buffer entry layout.
package core_pkg;

  localparam int NUM_ARCH_REGS = 4;
  localparam int DATA_W        = 8;
  localparam int REG_ADDR_W    = 2;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  has_dest;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit.sv
// In-order-retire reorder buffer: program-order allocation, tagged
// out-of-order writeback, and one retirement per cycle into the register file.
module rob_commit
  import core_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_W     = core_pkg::DATA_W,
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      alloc_valid,
  output logic                      alloc_ready,
  input  logic                      alloc_has_dest,
  input  logic [REG_ADDR_W-1:0]     alloc_dest,
  output logic [$clog2(DEPTH)-1:0]  alloc_tag,
  input  logic                      wb_valid,
  input  logic [$clog2(DEPTH)-1:0]  wb_tag,
  input  logic [DATA_W-1:0]         wb_data,
  output logic [REG_ADDR_W-1:0]     rf_write_register,
  output logic [DATA_W-1:0]         rf_write_data,
  output logic                      rf_write_enable,
  output logic                      commit_valid,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty
);

  localparam int TAG_W = $clog2(DEPTH);
  localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

  rob_entry_t       entries_q [DEPTH];
  rob_entry_t       entries_d [DEPTH];
  logic [TAG_W:0]   head_q, head_d;
  logic [TAG_W:0]   tail_q, tail_d;

  logic             full;
  logic             alloc_fire;
  rob_entry_t       head_entry;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign full       = (head_q[TAG_W-1:0] == tail_q[TAG_W-1:0]) &&
                      (head_q[TAG_W] != tail_q[TAG_W]);
  assign empty      = (head_q == tail_q);
  assign count      = tail_q - head_q;
  assign alloc_ready = !full;
  assign alloc_tag  = tail_q[TAG_W-1:0];
  assign alloc_fire = alloc_valid && alloc_ready && !flush;

  assign head_entry        = entries_q[head_q[TAG_W-1:0]];
  assign commit_valid      = head_entry.valid && head_entry.done && !flush;
  assign rf_write_enable   = commit_valid && head_entry.has_dest;
  assign rf_write_register = rf_write_enable ? head_entry.dest : '0;
  assign rf_write_data     = rf_write_enable ? head_entry.data : '0;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
    end

    if (flush) begin
      head_d = '0;
      tail_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
      end
    end else begin
      if (wb_valid && entries_q[wb_tag].valid) begin
        entries_d[wb_tag].data = wb_data;
        entries_d[wb_tag].done = 1'b1;
      end
      if (alloc_fire) begin
        entries_d[tail_q[TAG_W-1:0]].valid    = 1'b1;
        entries_d[tail_q[TAG_W-1:0]].done     = 1'b0;
        entries_d[tail_q[TAG_W-1:0]].has_dest = alloc_has_dest;
        entries_d[tail_q[TAG_W-1:0]].dest     = alloc_dest;
        tail_d = tail_q + PTR_ONE;
      end
      // Applied last so a stray writeback to the retiring entry cannot revive it.
      if (commit_valid) begin
        entries_d[head_q[TAG_W-1:0]].valid = 1'b0;
        entries_d[head_q[TAG_W-1:0]].done  = 1'b0;
        head_d = head_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit with hand-computed expected retirement traffic.
module tb_rob_commit;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       alloc_valid;
  logic       alloc_ready;
  logic       alloc_has_dest;
  logic [1:0] alloc_dest;
  logic [1:0] alloc_tag;
  logic       wb_valid;
  logic [1:0] wb_tag;
  logic [7:0] wb_data;
  logic [1:0] rf_write_register;
  logic [7:0] rf_write_data;
  logic       rf_write_enable;
  logic       commit_valid;
  logic [2:0] count;
  logic       empty;

  int checks;
  int errors;

  rob_commit #(.DEPTH(4), .DATA_W(8), .REG_ADDR_W(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .alloc_valid       (alloc_valid),
    .alloc_ready       (alloc_ready),
    .alloc_has_dest    (alloc_has_dest),
    .alloc_dest        (alloc_dest),
    .alloc_tag         (alloc_tag),
    .wb_valid          (wb_valid),
    .wb_tag            (wb_tag),
    .wb_data           (wb_data),
    .rf_write_register (rf_write_register),
    .rf_write_data     (rf_write_data),
    .rf_write_enable   (rf_write_enable),
    .commit_valid      (commit_valid),
    .count             (count),
    .empty             (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    flush          = 1'b0;
    alloc_valid    = 1'b0;
    alloc_has_dest = 1'b0;
    alloc_dest     = 2'd0;
    wb_valid       = 1'b0;
    wb_tag         = 2'd0;
    wb_data        = 8'd0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_alloc(input logic has_dest, input logic [1:0] dest);
    alloc_valid    = 1'b1;
    alloc_has_dest = has_dest;
    alloc_dest     = dest;
  endtask

  task automatic drive_wb(input logic [1:0] tag, input logic [7:0] data);
    wb_valid = 1'b1;
    wb_tag   = tag;
    wb_data  = data;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
  endtask

  task automatic chk_commit(input string tag, input logic cv, input logic we,
                            input logic [1:0] reg_a, input logic [7:0] data);
    chk({tag, "_cv"},   commit_valid,      cv);
    chk({tag, "_we"},   rf_write_enable,   we);
    chk({tag, "_reg"},  rf_write_register, reg_a);
    chk({tag, "_data"}, rf_write_data,     data);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    settle();
    chk("rst_ready", alloc_ready, 1);
    chk("rst_tag",   alloc_tag,   0);
    chk("rst_count", count,       0);
    chk("rst_empty", empty,       1);
    chk_commit("rst", 0, 0, 2'd0, 8'h00);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Single entry: alloc, writeback, retire one cycle later.
    drive_alloc(1'b1, 2'd1);
    settle();
    chk("t1_tag", alloc_tag, 0);
    cyc();
    drive_wb(2'd0, 8'h5A);
    settle();
    chk("t1_count", count, 1);
    chk("t1_nobypass", commit_valid, 0);
    cyc();
    settle();
    chk_commit("t1", 1, 1, 2'd1, 8'h5A);
    cyc();
    settle();
    chk("t1_count_end", count, 0);
    chk("t1_empty_end", empty, 1);
    do_flush();

    // Fill, out-of-order writeback, in-order retirement.
    for (int i = 0; i < 4; i++) begin
      drive_alloc(1'b1, 2'(i));
      settle();
      chk("t2_alloc_tag", alloc_tag, i);
      cyc();
    end
    settle();
    chk("t2_full_ready", alloc_ready, 0);
    chk("t2_full_count", count, 4);
    drive_wb(2'd3, 8'h33);
    cyc();
    drive_wb(2'd1, 8'h11);
    settle();
    chk("t2_wait1", commit_valid, 0);
    cyc();
    drive_wb(2'd0, 8'h00);
    settle();
    chk("t2_wait0", commit_valid, 0);
    cyc();
    drive_wb(2'd2, 8'h22);
    settle();
    chk_commit("t2_c0", 1, 1, 2'd0, 8'h00);
    cyc();
    settle();
    chk_commit("t2_c1", 1, 1, 2'd1, 8'h11);
    cyc();
    settle();
    chk_commit("t2_c2", 1, 1, 2'd2, 8'h22);
    cyc();
    settle();
    chk_commit("t2_c3", 1, 1, 2'd3, 8'h33);
    cyc();
    settle();
    chk("t2_empty", empty, 1);
    chk("t2_wrap_tag", alloc_tag, 0);

    // Entry without a destination retires silently.
    drive_alloc(1'b0, 2'd2);
    cyc();
    drive_wb(2'd0, 8'h77);
    cyc();
    settle();
    chk_commit("t3", 1, 0, 2'd0, 8'h00);
    cyc();
    settle();
    chk("t3_count", count, 0);
    chk("t3_head_adv_tag", alloc_tag, 1);
    do_flush();

    // Commit while full does not grant a same-cycle alloc.
    for (int i = 0; i < 4; i++) begin
      drive_alloc(1'b1, 2'(i));
      cyc();
    end
    drive_wb(2'd0, 8'h44);
    cyc();
    drive_alloc(1'b1, 2'd3);
    settle();
    chk("t4_ready_full", alloc_ready, 0);
    chk_commit("t4_c0", 1, 1, 2'd0, 8'h44);
    cyc();
    drive_alloc(1'b1, 2'd3);
    settle();
    chk("t4_count3", count, 3);
    chk("t4_ready", alloc_ready, 1);
    chk("t4_wrap_tag", alloc_tag, 0);
    cyc();
    settle();
    chk("t4_count4", count, 4);
    chk("t4_full_again", alloc_ready, 0);
    do_flush();

    // Flush overrides a pending commit, alloc and writeback.
    for (int i = 0; i < 3; i++) begin
      drive_alloc(1'b1, 2'(i + 1));
      cyc();
    end
    drive_wb(2'd1, 8'hA1);
    cyc();
    drive_wb(2'd0, 8'hA0);
    cyc();
    flush = 1'b1;
    drive_alloc(1'b1, 2'd3);
    drive_wb(2'd2, 8'hA2);
    settle();
    chk_commit("t5_flush", 0, 0, 2'd0, 8'h00);
    cyc();
    settle();
    chk("t5_count", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_tag", alloc_tag, 0);
    chk("t5_cv", commit_valid, 0);

    // Writeback to an unallocated entry must not mark it done.
    drive_wb(2'd2, 8'hFF);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive_alloc(1'b1, 2'(i + 1));
      cyc();
    end
    drive_wb(2'd0, 8'h10);
    cyc();
    drive_wb(2'd1, 8'h20);
    settle();
    chk_commit("t6_c0", 1, 1, 2'd1, 8'h10);
    cyc();
    settle();
    chk_commit("t6_c1", 1, 1, 2'd2, 8'h20);
    cyc();
    settle();
    chk("t6_stall", commit_valid, 0);
    chk("t6_count", count, 1);
    drive_wb(2'd2, 8'h30);
    cyc();
    settle();
    chk_commit("t6_c2", 1, 1, 2'd3, 8'h30);
    cyc();
    settle();
    chk("t6_empty", empty, 1);

    // Asynchronous reset in the middle of a retirement cycle.
    drive_alloc(1'b1, 2'd2);
    cyc();
    drive_wb(2'd3, 8'h66);
    cyc();
    settle();
    chk("t7_pre_cv", commit_valid, 1);
    rst_n = 1'b0;
    settle();
    chk_commit("t7_rst", 0, 0, 2'd0, 8'h00);
    chk("t7_rst_count", count, 0);
    chk("t7_rst_tag", alloc_tag, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    settle();
    chk("t7_after_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
